fft_frame_unloader: RTL and testbench

Output-side counterpart of the iterative FFT input interface. It accepts one full frame of 2**AWL complex results, streamed with a VALID strobe and no back-pressure. It holds the frame in a local buffer and hands samples one at a time to a downstream reader through a pull handshake (i_RD / o_RD_VALID). It sits between top_fft_iter's o_DATA_R/o_DATA_I/VALID and the consumer: result DMA, a file-dump bench, or a magnitude block.

---
 rtl/fft_unload_pkg.sv | 26 ++
 rtl/fft_unload_ram.sv | 39 +++
 rtl/fft_frame_unloader.sv | 126 ++++++++++++
 tb/tb_fft_frame_unloader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_unload_pkg.sv
// fft_unload_pkg: shared state encoding, default sizing and bit-reversal helper
// for the FFT frame unloader.
`default_nettype none
package fft_unload_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   localparam int AWL_DEFAULT = 11;
   localparam int DWL_DEFAULT = 16;
   localparam int N_DEFAULT   = 2**AWL_DEFAULT;

   // Reverses the low w bits of v; higher bits of the result are zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         r[i] = v[w-1-i];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fft_unload_ram.sv
// fft_unload_ram: simple dual-port frame buffer, one write port and one read
// port whose registered output gives a fixed one-cycle read latency.
`default_nettype none
module fft_unload_ram
   import fft_unload_pkg::*;
#(
   parameter int WIDTH = 2*DWL_DEFAULT,
   parameter int AW    = AWL_DEFAULT,
   parameter int DEPTH = N_DEFAULT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register holds its value between reads so the data outputs stay put.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/fft_frame_unloader.sv
// fft_frame_unloader: buffers one 2**AWL-sample FFT result frame and hands it
// to a reader via a pull handshake. Option macro: FFT_UNLOAD_BITREV_EN.
`default_nettype none
module fft_frame_unloader
   import fft_unload_pkg::*;
#(
   parameter int DWL = DWL_DEFAULT,
   parameter int AWL = AWL_DEFAULT
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           EN,
   input  logic [DWL-1:0] i_DATA_R,
   input  logic [DWL-1:0] i_DATA_I,
   input  logic           i_VALID,
   input  logic           i_RD,
   input  logic           i_CLR_OVF,
   output logic [DWL-1:0] o_DATA_R,
   output logic [DWL-1:0] o_DATA_I,
   output logic           o_RD_VALID,
   output logic           o_LAST,
   output logic           o_FRAME_RDY,
   output logic           o_OVF,
   output logic [AWL-1:0] o_WR_CNT
);

   localparam int N = 2**AWL;

   state_t             state;
   logic [AWL-1:0]     wr_cnt;
   logic [AWL-1:0]     rd_cnt;
   logic               rd_valid;
   logic               last;
   logic               frame_rdy;
   logic               ovf;
   logic [AWL-1:0]     wr_addr;
   logic [2*DWL-1:0]   rdata;

   logic pop;
   logic last_pop;
   logic wr_ok;
   logic drop;
   logic wr_end;

   assign pop      = EN & i_RD & (state == DRAIN);
   assign last_pop = pop & (&rd_cnt);
   // A sample coinciding with the final pop is the first of the next frame.
   assign wr_ok    = EN & i_VALID & ((state == FILL) | last_pop);
   assign drop     = EN & i_VALID & (state == DRAIN) & ~last_pop;
   assign wr_end   = wr_ok & (state == FILL) & (&wr_cnt);

`ifdef FFT_UNLOAD_BITREV_EN
   assign wr_addr = AWL'(bitrev(32'(wr_cnt), AWL));
`else
   assign wr_addr = wr_cnt;
`endif

   fft_unload_ram #(
      .WIDTH (2*DWL),
      .AW    (AWL),
      .DEPTH (N)
   ) u_ram (
      .CLK   (CLK),
      .RST   (RST),
      .we    (wr_ok),
      .waddr (wr_addr),
      .wdata ({i_DATA_R, i_DATA_I}),
      .re    (pop),
      .raddr (rd_cnt),
      .rdata (rdata)
   );

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= FILL;
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         rd_valid  <= 1'b0;
         last      <= 1'b0;
         frame_rdy <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         // Read strobes track the pop of the previous cycle only.
         rd_valid <= pop;
         last     <= last_pop;
         if (EN) begin
            if (wr_ok) begin
               wr_cnt <= wr_cnt + 1'b1;
            end
            if (pop) begin
               rd_cnt <= rd_cnt + 1'b1;
            end
            if (drop) begin
               ovf <= 1'b1;
            end else if (i_CLR_OVF) begin
               ovf <= 1'b0;
            end
            case (state)
               FILL: begin
                  if (wr_end) begin
                     state     <= DRAIN;
                     frame_rdy <= 1'b1;
                  end
               end
               DRAIN: begin
                  if (last_pop) begin
                     state     <= FILL;
                     frame_rdy <= 1'b0;
                  end
               end
               default: state <= FILL;
            endcase
         end
      end
   end

   assign o_DATA_R    = rdata[2*DWL-1:DWL];
   assign o_DATA_I    = rdata[DWL-1:0];
   assign o_RD_VALID  = rd_valid;
   assign o_LAST      = last;
   assign o_FRAME_RDY = frame_rdy;
   assign o_OVF       = ovf;
   assign o_WR_CNT    = wr_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_unloader.sv
// tb_fft_frame_unloader: directed and random stimulus for fft_frame_unloader
// (AWL=3), checked against a frame-level reference model every cycle.
`default_nettype none
module tb_fft_frame_unloader;

   localparam int DWL = 16;
   localparam int AWL = 3;
   localparam int N   = 8;

   logic           CLK = 1'b0;
   logic           RST = 1'b0;
   logic           EN = 1'b0;
   logic [DWL-1:0] i_DATA_R = '0;
   logic [DWL-1:0] i_DATA_I = '0;
   logic           i_VALID = 1'b0;
   logic           i_RD = 1'b0;
   logic           i_CLR_OVF = 1'b0;
   logic [DWL-1:0] o_DATA_R;
   logic [DWL-1:0] o_DATA_I;
   logic           o_RD_VALID;
   logic           o_LAST;
   logic           o_FRAME_RDY;
   logic           o_OVF;
   logic [AWL-1:0] o_WR_CNT;

   fft_frame_unloader #(.DWL(DWL), .AWL(AWL)) dut (
      .CLK(CLK), .RST(RST), .EN(EN),
      .i_DATA_R(i_DATA_R), .i_DATA_I(i_DATA_I), .i_VALID(i_VALID),
      .i_RD(i_RD), .i_CLR_OVF(i_CLR_OVF),
      .o_DATA_R(o_DATA_R), .o_DATA_I(o_DATA_I), .o_RD_VALID(o_RD_VALID),
      .o_LAST(o_LAST), .o_FRAME_RDY(o_FRAME_RDY), .o_OVF(o_OVF),
      .o_WR_CNT(o_WR_CNT)
   );

   always #5 CLK = ~CLK;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   logic [31:0] got[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a frame array plus "draining" flag and sample indices.
   logic [31:0] fbuf [N];
   bit          draining = 0;
   int          widx = 0;
   int          ridx = 0;
   bit          m_valid = 0, m_last = 0, m_ovf = 0;
   logic [31:0] m_data = '0;

   function automatic int place(input int k);
`ifdef FFT_UNLOAD_BITREV_EN
      return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
`else
      return k;
`endif
   endfunction

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         draining = 0; widx = 0; ridx = 0;
         m_valid = 0; m_last = 0; m_ovf = 0; m_data = '0;
      end else if (!EN) begin
         m_valid = 0; m_last = 0;
      end else begin
         bit popped, fin, accepted, dropped, full;
         popped   = draining && i_RD;
         fin      = popped && (ridx == N-1);
         accepted = i_VALID && (!draining || fin);
         dropped  = i_VALID && !accepted;
         full     = 0;
         m_valid  = popped;
         m_last   = fin;
         if (popped) begin
            m_data = fbuf[ridx];
            ridx   = (ridx + 1) % N;
         end
         if (accepted) begin
            fbuf[place(widx)] = {i_DATA_R, i_DATA_I};
            full = !draining && (widx == N-1);
            widx = (widx + 1) % N;
         end
         if (dropped) m_ovf = 1;
         else if (i_CLR_OVF) m_ovf = 0;
         if (fin) draining = 0;
         if (full) draining = 1;
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("rd_valid", 64'(o_RD_VALID), 64'(m_valid));
         check("last", 64'(o_LAST), 64'(m_last));
         check("frame_rdy", 64'(o_FRAME_RDY), 64'(draining));
         check("ovf", 64'(o_OVF), 64'(m_ovf));
         check("wr_cnt", 64'(o_WR_CNT), 64'(widx));
         check("data", 64'({o_DATA_R, o_DATA_I}), 64'(m_data));
         if (o_RD_VALID === 1'b1) got.push_back({o_DATA_R, o_DATA_I});
      end
   end

   task automatic cyc(input bit en, input bit v, input bit rd, input bit clr,
                      input logic [15:0] dr, input logic [15:0] di);
      @(negedge CLK);
      EN = en; i_VALID = v; i_RD = rd; i_CLR_OVF = clr;
      i_DATA_R = dr; i_DATA_I = di;
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      cyc(1, 0, 0, 0, 16'h0, 16'h0);
   endtask

   task automatic sample(input int k);
      cyc(1, 1, 0, 0, 16'(k), 16'(-k));
   endtask

   task automatic drain8();
      got.delete();
      for (int i = 0; i < N; i++) cyc(1, 0, 1, 0, 16'h0, 16'h0);
      idle();
   endtask

   task automatic check_got(input string nm, input int base);
      check({nm, "_count"}, 64'(got.size()), 64'(N));
      for (int k = 0; k < N && k < got.size(); k++)
         check(nm, 64'(got[k]), 64'({16'(base + k), 16'(-(base + k))}));
   endtask

   int order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk_en = 1'b1;
      check("reset_outs", 64'({o_DATA_R, o_DATA_I, o_RD_VALID, o_LAST, o_FRAME_RDY, o_OVF, o_WR_CNT}), 64'h0);
      RST = 1'b1;

      // Fill and drain one frame.
      for (int k = 0; k < N; k++) begin
         sample(k);
         check("frame_rdy_fill", 64'(o_FRAME_RDY), (k == N-1) ? 64'd1 : 64'd0);
      end
      got.delete();
      for (int i = 0; i < N; i++) begin
         cyc(1, 0, 1, 0, 16'h0, 16'h0);
         check("pulse", 64'(o_RD_VALID), 64'd1);
         check("last_lit", 64'(o_LAST), (i == N-1) ? 64'd1 : 64'd0);
      end
      idle();
      check("valid_after", 64'(o_RD_VALID), 64'd0);
      check_got("fd_data", 0);
      check("rdy_after", 64'(o_FRAME_RDY), 64'd0);
      check("ovf_fd", 64'(o_OVF), 64'd0);

      // Overflow: two extra samples are dropped.
      for (int k = 0; k < N; k++) sample(10 + k);
      sample(99); sample(98);
      check("ovf_set", 64'(o_OVF), 64'd1);
      check("ovf_wrcnt", 64'(o_WR_CNT), 64'd0);
      drain8();
      check_got("ovf_data", 10);
      cyc(1, 0, 0, 1, 16'h0, 16'h0);
      check("ovf_clr", 64'(o_OVF), 64'd0);

      // Boundary: sample arrives with the final pop.
      for (int k = 0; k < N; k++) sample(30 + k);
      for (int i = 0; i < N-1; i++) cyc(1, 0, 1, 0, 16'h0, 16'h0);
      cyc(1, 1, 1, 0, 16'h0055, 16'h00AA);
      check("bnd_last", 64'(o_LAST), 64'd1);
      check("bnd_ovf", 64'(o_OVF), 64'd0);
      check("bnd_wrcnt", 64'(o_WR_CNT), 64'd1);
      for (int k = 1; k < N; k++) sample(40 + k);
      drain8();
      check("bnd_s0", 64'(got[0]), 64'h005500AA);
      check("bnd_s1", 64'(got[1]), 64'({16'd41, 16'(-41)}));

      // Sparse pops with EN low mid-drain.
      for (int k = 0; k < N; k++) sample(50 + k);
      got.delete();
      begin
         int pops = 0;
         for (int i = 0; i < 100 && pops < N; i++) begin
            bit en, rd;
            en = !(i == 7 || i == 8);
            rd = en && (i % 3 == 0);
            if (rd) pops++;
            cyc(en, 0, rd, 0, 16'h0, 16'h0);
            if (!en) check("no_pulse_en0", 64'(o_RD_VALID), 64'd0);
         end
      end
      idle(); idle();
      check_got("sparse", 50);

      // Async reset mid-frame.
      for (int k = 0; k < 5; k++) sample(60 + k);
      check("pre_rst_wrcnt", 64'(o_WR_CNT), 64'd5);
      @(negedge CLK);
      EN = 0; i_VALID = 0; i_RD = 0;
      #2 RST = 1'b0;
      #1 check("async_rst", 64'({o_DATA_R, o_DATA_I, o_RD_VALID, o_LAST, o_FRAME_RDY, o_OVF, o_WR_CNT}), 64'h0);
      @(negedge CLK);
      RST = 1'b1;
      for (int k = 0; k < N; k++) sample(70 + k);
      drain8();
      check_got("post_rst", 70);

      // Feed in bit-reversed order.
      for (int k = 0; k < N; k++) sample(order[k]);
      drain8();
      for (int k = 0; k < N; k++) begin
`ifdef FFT_UNLOAD_BITREV_EN
         check("bitrev", 64'(got[k][31:16]), 64'(k));
`else
         check("natural", 64'(got[k][31:16]), 64'(order[k]));
`endif
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(9, 0) != 0, $urandom_range(1, 0) == 1,
             $urandom_range(1, 0) == 1, $urandom_range(9, 0) == 0,
             16'($urandom), 16'($urandom));
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
